// File: rtl/mac_accum_q312_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared constants for the Q3.12 multiply-accumulate engine and its
// saturator: operand/result formats, saturation rails, and a helper that
// gives the smallest accumulator width that can never wrap for a given
// vector length.
// ---------------------------------------------------------------------------
package mac_pkg;

   // Operand format: signed Q3.12
   localparam int OP_W     = 16;
   localparam int OP_FRAC  = 12;

   // Result format: signed Q7.24 (product of two Q3.12 values lands on 24
   // fractional bits, so no realignment is needed between product and sum)
   localparam int OUT_W    = 32;
   localparam int OUT_FRAC = 24;

   localparam logic [OUT_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [OUT_W-1:0] SAT_MIN = 32'h8000_0000;

   // Each product fits in 32 bits; summing len of them needs clog2(len)
   // extra bits, plus one more so a bias term can never push it over.
   function automatic int min_acc_w(input int len);
      return OUT_W + $clog2(len) + 1;
   endfunction

endpackage

// File: rtl/mac_accum_q312_sat_clip.sv
// ---------------------------------------------------------------------------
// sat_clip
// Combinational clip of a wide signed accumulator value to 32-bit signed.
// Ports:
//   din  - ACC_W-bit signed value
//   dout - value clipped to [SAT_MIN, SAT_MAX]
//   ovf  - set when din lies outside the 32-bit signed range
// ---------------------------------------------------------------------------
module sat_clip
   import mac_pkg::*;
#(
   parameter int ACC_W = 42
) (
   input  logic signed [ACC_W-1:0] din,
   output logic        [OUT_W-1:0] dout,
   output logic                    ovf
);

   // The value fits in 32 bits exactly when every bit from the 32-bit sign
   // position upwards agrees; any disagreement means it overflowed, and the
   // true sign (top bit) picks which rail to clamp to.
   always_comb begin
      ovf  = !((&din[ACC_W-1:OUT_W-1]) || !(|din[ACC_W-1:OUT_W-1]));
      dout = din[OUT_W-1:0];
      if (ovf) begin
         dout = din[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/mac_accum_q312.sv
// ---------------------------------------------------------------------------
// mac_accum_q312
// Streaming dot-product engine: multiply-accumulates LEN pairs of signed
// Q3.12 operands and emits one saturated signed Q7.24 sum per vector.
// Optional feature macro: MAC_ACCUM_BIAS_EN (adds a Q7.24 bias port that
// seeds the sum, sampled on the first beat of each vector).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - operand pair handshake (in_a, in_w are Q3.12)
//   out_valid/out_ready - result handshake
//   out_data            - saturated Q7.24 dot product
//   out_sat             - saturation occurred for this result
//   bias                - (MAC_ACCUM_BIAS_EN only) Q7.24 starting value
//   busy                - a vector is partially accumulated
// ---------------------------------------------------------------------------
module mac_accum_q312
   import mac_pkg::*;
#(
   parameter int LEN   = 4,
   parameter int ACC_W = 42
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_w,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
`ifdef MAC_ACCUM_BIAS_EN
   input  logic [OUT_W-1:0]  bias,
`endif
   output logic              busy
);

   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   // Refuse to build a configuration whose accumulator could wrap, or whose
   // formats no longer line up product-to-result without a shift.
   if ((ACC_W < min_acc_w(LEN)) || (2 * OP_FRAC != OUT_FRAC)) begin : g_bad_cfg
      $error("mac_accum_q312: ACC_W too small for LEN or format mismatch");
   end

   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [OUT_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] sum;
   logic [OUT_W-1:0]        sum_sat;
   logic                    sum_ovf;
   logic                    beat;
   logic                    last;

   // No skid buffer: a new pair is only taken when the output register is
   // empty or is being drained in this same cycle.
   assign in_ready = !out_valid || out_ready;
   assign beat     = in_valid && in_ready;
   assign last     = (cnt == CNT_LAST);
   assign busy     = (cnt != '0);

   assign prod     = $signed(in_a) * $signed(in_w);
   assign prod_ext = {{(ACC_W-OUT_W){prod[OUT_W-1]}}, prod};

`ifdef MAC_ACCUM_BIAS_EN
   assign base = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
`else
   assign base = '0;
`endif

   // The first beat of a vector starts from base rather than the stale acc,
   // which also covers LEN=1 where every beat is both first and last.
   assign sum = ((cnt == '0) ? base : acc) + prod_ext;

   sat_clip #(
      .ACC_W (ACC_W)
   ) u_sat_clip (
      .din  (sum),
      .dout (sum_sat),
      .ovf  (sum_ovf)
   );

   // Beat counter and running sum. On the last beat the sum goes to the
   // output register instead, and acc is cleared ready for the next vector.
   // Stalled cycles (no beat) leave both untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (beat) begin
         if (last) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc <= sum;
         end
      end
   end

   // Output register. A last beat always loads a fresh result, even in the
   // same cycle the previous one drains, so back-to-back vectors lose no
   // cycles. Otherwise data and flag stay frozen until they are taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (beat && last) begin
         out_valid <= 1'b1;
         out_data  <= sum_sat;
         out_sat   <= sum_ovf;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_accum_q312.sv
// ---------------------------------------------------------------------------
// tb_mac_accum_q312
// Directed bench for mac_accum_q312 (LEN=4). Expected results are pushed to
// a scoreboard queue as each vector's last beat is accepted; an independent
// monitor pops and compares on every output transfer. Build with
// MAC_ACCUM_BIAS_EN defined to also exercise the bias port.
// ---------------------------------------------------------------------------
module tb_mac_accum_q312;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_a      = '0;
   logic [15:0] in_w      = '0;
   logic [31:0] bias_r    = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_sat;
   logic        busy;
   logic [31:0] out_data;

   typedef struct packed {
      logic [31:0] data;
      logic        sat;
   } exp_t;

   exp_t sb[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   pushed  = 0;
   int   popped  = 0;

   mac_accum_q312 #(
      .LEN   (4),
      .ACC_W (42)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_w      (in_w),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
`ifdef MAC_ACCUM_BIAS_EN
      .bias      (bias_r),
`endif
      .busy      (busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One scalar comparison, counted toward the summary
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      vec_cnt++;
      if (act !== req) begin
         err_cnt++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Present one operand pair and hold it until the DUT takes it. Inputs
   // change just after a rising edge; acceptance is judged from in_ready
   // at the falling edge before the capturing edge.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] w);
      logic ok;
      ok       = 1'b0;
      in_a     = a;
      in_w     = w;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         vec_cnt++;
         err_cnt++;
         $display("[TB] FAIL beat_timeout: got in_ready=0 expected 1 within 200 cycles");
      end
   endtask

   // Four beats (first listed first); bias b0 on the first beat and a
   // different value on the rest, which must be ignored.
   task automatic sendVector(input logic [3:0][15:0] av, input logic [3:0][15:0] wv,
                             input logic [31:0] b0, input logic [31:0] ed,
                             input logic es);
      for (int k = 3; k >= 0; k--) begin
         bias_r = (k == 3) ? b0 : ~b0;
         applyStimulus(av[k], wv[k]);
      end
      sb.push_back('{data: ed, sat: es});
      pushed++;
      checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("drain_queue_empty", sb.size(), 32'd0);
   endtask

   // Monitor: a result transfers at the rising edge after a falling edge
   // that sees out_valid && out_ready, so each transfer is seen exactly once.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         vec_cnt++;
         if (sb.size() == 0) begin
            err_cnt++;
            $display("[TB] FAIL unexpected_result: got 0x%08h expected none", out_data);
         end else begin
            e = sb.pop_front();
            popped++;
            if (out_data !== e.data || out_sat !== e.sat) begin
               err_cnt++;
               $display("[TB] FAIL result: got data=0x%08h sat=%0b expected data=0x%08h sat=%0b",
                        out_data, out_sat, e.data, e.sat);
            end
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_out_data",  out_data,           32'd0);
      checkOutput("reset_out_sat",   {31'd0, out_sat},   32'd0);
      checkOutput("reset_busy",      {31'd0, busy},      32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back vectors with out_ready held high
      sendVector({16'h1000, 16'h1000, 16'h1000, 16'h1000},
                 {16'h1000, 16'h1000, 16'h1000, 16'h1000}, 32'h0, 32'h0400_0000, 1'b0);
      sendVector({16'h8000, 16'h8000, 16'h8000, 16'h8000},
                 {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 32'h0, 32'h7FFF_FFFF, 1'b1);
      sendVector({16'h8000, 16'h8000, 16'h8000, 16'h8000},
                 {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 32'h0, 32'h8000_0000, 1'b1);
      // Exactly 2^31-1 and exactly -2^31: on the rails but not saturated
      sendVector({16'h8000, 16'h8000, 16'h0001, 16'h0000},
                 {16'h8000, 16'h8000, 16'hFFFF, 16'h0000}, 32'h0, 32'h7FFF_FFFF, 1'b0);
      sendVector({16'h8000, 16'h8000, 16'hFFF0, 16'h0000},
                 {16'h7FFF, 16'h7FFF, 16'h1000, 16'h0000}, 32'h0, 32'h8000_0000, 1'b0);
      sendVector({16'h1000, 16'h1000, 16'h1000, 16'h1000},
                 {16'hF000, 16'hF000, 16'hF000, 16'hF000}, 32'h0, 32'hFC00_0000, 1'b0);
`ifdef MAC_ACCUM_BIAS_EN
      sendVector({16'h1000, 16'h1000, 16'h1000, 16'h1000},
                 {16'h1000, 16'h1000, 16'h1000, 16'h1000}, 32'hFF00_0000, 32'h0300_0000, 1'b0);
`endif
      waitDrain();

      // Backpressure: result parks, input stalls, then both flow in order
      out_ready = 1'b0;
      sendVector({16'h1000, 16'h1000, 16'h1000, 16'h1000},
                 {16'h1000, 16'h1000, 16'h1000, 16'h1000}, 32'h0, 32'h0400_0000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_in_ready_low", {31'd0, in_ready},  32'd0);
      checkOutput("bp_out_valid",    {31'd0, out_valid}, 32'd1);
      checkOutput("bp_data_held",    out_data,           32'h0400_0000);
      fork
         sendVector({16'h1000, 16'h1000, 16'h1000, 16'h1000},
                    {16'h0800, 16'h0800, 16'h0800, 16'h0800}, 32'h0, 32'h0200_0000, 1'b0);
         begin
            repeat (5) @(posedge clk);
            #1;
            checkOutput("bp_stall_busy",  {31'd0, busy}, 32'd0);
            checkOutput("bp_data_stable", out_data,      32'h0400_0000);
            out_ready = 1'b1;
         end
      join
      waitDrain();
      checkOutput("bp_in_order_count", popped, pushed);

      // Reset mid-vector discards the partial sum
      applyStimulus(16'h1000, 16'h1000);
      applyStimulus(16'h1000, 16'h1000);
      checkOutput("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midrst_out_data",  out_data,           32'd0);
      checkOutput("midrst_busy",      {31'd0, busy},      32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sendVector({16'h1000, 16'h1000, 16'h1000, 16'h1000},
                 {16'h0800, 16'h0800, 16'h0800, 16'h0800}, 32'h0, 32'h0200_0000, 1'b0);
      waitDrain();
      checkOutput("final_in_order_count", popped, pushed);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
